// File: rtl/iob_fp_float2int_pkg.sv
// iob_fp_float2int_pkg: shared FP field widths, class bundle, canonical NaN/inf encodings and integer saturation constants
package iob_fp_float2int_pkg;
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
  } fp_class_t;
  function automatic int man_w(input int data_w, input int exp_w);
    return data_w - exp_w;
  endfunction
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [63:0] fp_nan(input int data_w, input int exp_w);
    return (((64'd1 << exp_w) - 64'd1) << (data_w - exp_w - 1)) | (64'd1 << (data_w - exp_w - 2));
  endfunction
  function automatic logic [63:0] fp_inf(input logic sign, input int data_w, input int exp_w);
    return (64'(sign) << (data_w - 1)) | (((64'd1 << exp_w) - 64'd1) << (data_w - exp_w - 1));
  endfunction
  function automatic logic [63:0] int_max(input int int_w);
    return (64'd1 << (int_w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] int_min(input int int_w);
    return 64'd1 << (int_w - 1);
  endfunction
endpackage

// File: rtl/iob_fp_special.sv
// iob_fp_special: classifies a packed float (op_i) into nan_o/infinite_o/zero_o/sub_normal_o
module iob_fp_special #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] op_i,
  output logic              nan_o,
  output logic              infinite_o,
  output logic              zero_o,
  output logic              sub_normal_o
);
  logic [EXP_W-1:0] ex;
  logic             frac_nz;
  assign ex           = op_i[DATA_W-2 -: EXP_W];
  assign frac_nz      = |op_i[DATA_W-EXP_W-2:0];
  assign nan_o        = &ex & frac_nz;
  assign infinite_o   = &ex & ~frac_nz;
  assign zero_o       = ~|ex & ~frac_nz;
  assign sub_normal_o = ~|ex & frac_nz;
endmodule

// File: rtl/iob_fp_float2int.sv
// iob_fp_float2int: pipelined float->int truncating converter; start_i/op_i in, done_o/res_o/overflow_o/exception_o/inexact_o out
module iob_fp_float2int
  import iob_fp_float2int_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int INT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_i,
  output logic              done_o,
  output logic [INT_W-1:0]  res_o,
  output logic              overflow_o,
  output logic              exception_o,
  output logic              inexact_o
);
  localparam int MAN_W = man_w(DATA_W, EXP_W);
  localparam int F_W = MAN_W - 1;
  localparam logic signed [EXP_W:0] BIAS_E = (EXP_W+1)'(bias(EXP_W));
  localparam logic signed [EXP_W:0] F_E = (EXP_W+1)'(F_W);
  localparam logic signed [EXP_W:0] TOP_E = (EXP_W+1)'(INT_W - 1);
  localparam logic [INT_W-1:0] INT_MAX = INT_W'(int_max(INT_W));
  localparam logic [INT_W-1:0] INT_MIN = INT_W'(int_min(INT_W));
  logic nan, inf, zero, sub;
  fp_class_t cls0_d, cls0_q, cls1_q;
  logic v0_q, v1_q, v2_q, done_q;
  logic [DATA_W-1:0] op0_q;
  logic sign1_q;
  logic [MAN_W-1:0] mant1_d, mant1_q;
  logic signed [EXP_W:0] e1_d, e1_q;
  logic sat2_d, sat2_q, neg2_d, neg2_q, ovf2_d, ovf2_q, exc2_d, exc2_q, inx2_d, inx2_q;
  logic [INT_W-1:0] mag2_d, mag2_q, res_d, res_q;
  logic ovf_q, exc_q, inx_q;
  logic lft, lo, rng;
  logic [EXP_W:0] lsh, rsh;
  logic [2*MAN_W-1:0] wide;
  logic [INT_W-1:0] mag_n;
  iob_fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_special (
    .op_i        (op_i),
    .nan_o       (nan),
    .infinite_o  (inf),
    .zero_o      (zero),
    .sub_normal_o(sub)
  );
  assign cls0_d  = {nan, inf, zero, sub};
  assign e1_d    = $signed({1'b0, op0_q[DATA_W-2 -: EXP_W]}) - BIAS_E;
  assign mant1_d = {1'b1, op0_q[F_W-1:0]};
  always_comb begin
    lft    = e1_q >= F_E;
    lsh    = e1_q - F_E;
    rsh    = F_E - e1_q;
    wide   = {mant1_q, {MAN_W{1'b0}}} >> rsh;
    mag_n  = lft ? INT_W'(mant1_q) << lsh : INT_W'(wide[2*MAN_W-1:MAN_W]);
    lo     = cls1_q.zero | cls1_q.sub | e1_q[EXP_W];
    // the most negative integer is representable, so e == INT_W-1 with an empty fraction is in range when negative
    rng    = (e1_q >= TOP_E) & ~(sign1_q & (e1_q == TOP_E) & ~|mant1_q[F_W-1:0]);
    sat2_d = cls1_q.nan | (~lo & rng);
    neg2_d = sign1_q & ~cls1_q.nan;
    mag2_d = lo ? '0 : mag_n;
    ovf2_d = ~cls1_q.nan & ~lo & rng;
    exc2_d = cls1_q.nan | cls1_q.inf;
    inx2_d = lo ? ~cls1_q.zero : ~rng & ~lft & |wide[MAN_W-1:0];
    res_d  = sat2_q ? (neg2_q ? INT_MIN : INT_MAX) : neg2_q ? -mag2_q : mag2_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v0_q    <= 1'b0;
      op0_q   <= '0;
      cls0_q  <= '0;
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mant1_q <= '0;
      e1_q    <= '0;
      cls1_q  <= '0;
      v2_q    <= 1'b0;
      sat2_q  <= 1'b0;
      neg2_q  <= 1'b0;
      mag2_q  <= '0;
      ovf2_q  <= 1'b0;
      exc2_q  <= 1'b0;
      inx2_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      exc_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      v0_q    <= start_i;
      op0_q   <= op_i;
      cls0_q  <= cls0_d;
      v1_q    <= v0_q;
      sign1_q <= op0_q[DATA_W-1];
      mant1_q <= mant1_d;
      e1_q    <= e1_d;
      cls1_q  <= cls0_q;
      v2_q    <= v1_q;
      sat2_q  <= sat2_d;
      neg2_q  <= neg2_d;
      mag2_q  <= mag2_d;
      ovf2_q  <= ovf2_d;
      exc2_q  <= exc2_d;
      inx2_q  <= inx2_d;
      done_q  <= v2_q;
      res_q   <= res_d;
      ovf_q   <= ovf2_q;
      exc_q   <= exc2_q;
      inx_q   <= inx2_q;
    end
  end
  assign done_o      = done_q;
  assign res_o       = res_q;
  assign overflow_o  = ovf_q;
  assign exception_o = exc_q;
  assign inexact_o   = inx_q;
endmodule

// File: tb/tb_iob_fp_float2int.sv
// tb_iob_fp_float2int: table, hand-written and random checks of iob_fp_float2int against a value-level model
module tb_iob_fp_float2int;
  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        ovf;
    logic        exc;
    logic        inx;
  } vec_t;
  typedef struct {
    int          id;
    int          due;
    logic [31:0] res;
    logic        ovf;
    logic        exc;
    logic        inx;
  } exp_t;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;
  logic clk = 1'b0;
  logic rst_n_i = 1'b1;
  logic start_i = 1'b0;
  logic [31:0] op_i = '0;
  logic done_o, overflow_o, exception_o, inexact_o;
  logic [31:0] res_o;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t mx;
  vec_t tbl[15];
  iob_fp_float2int #(.DATA_W(32), .EXP_W(8), .INT_W(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .done_o     (done_o),
    .res_o      (res_o),
    .overflow_o (overflow_o),
    .exception_o(exception_o),
    .inexact_o  (inexact_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask
  // truncating conversion worked out on the numeric value, then range-checked against the int32 limits
  function automatic exp_t model(input logic [31:0] f, input int id);
    exp_t r;
    int e;
    longint m, ip, v;
    bit fnz;
    r = '{id: id, due: 0, res: 32'h0, ovf: 1'b0, exc: 1'b0, inx: 1'b0};
    fnz = 1'b0;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF) begin
      r.exc = 1'b1;
      if (f[22:0] != 0) r.res = 32'h7FFFFFFF;
      else begin
        r.ovf = 1'b1;
        r.res = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
      end
      return r;
    end
    if (f[30:23] == 8'h00) begin
      r.inx = f[22:0] != 0;
      return r;
    end
    if (e < 0) begin
      r.inx = 1'b1;
      return r;
    end
    m = longint'({1'b1, f[22:0]});
    if (e > 40) ip = 64'sh7FFF_FFFF_FFFF;
    else if (e >= 23) ip = m << (e - 23);
    else begin
      ip = m >> (23 - e);
      fnz = (m % (longint'(1) << (23 - e))) != 0;
    end
    v = f[31] ? -ip : ip;
    if (v > LMAX || v < LMIN) begin
      r.ovf = 1'b1;
      r.res = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end else begin
      r.res = v[31:0];
      r.inx = fnz;
    end
    return r;
  endfunction
  task automatic issue(input bit s, input logic [31:0] op, input exp_t x);
    @(negedge clk);
    start_i = s;
    op_i = op;
    if (s) begin
      x.due = cyc + 4;
      q.push_back(x);
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        mx = q.pop_front();
        chk($sformatf("done[%0d]", mx.id), {31'b0, done_o}, 32'd1);
        chk($sformatf("res[%0d]", mx.id), res_o, mx.res);
        chk($sformatf("ovf[%0d]", mx.id), {31'b0, overflow_o}, {31'b0, mx.ovf});
        chk($sformatf("exc[%0d]", mx.id), {31'b0, exception_o}, {31'b0, mx.exc});
        chk($sformatf("inx[%0d]", mx.id), {31'b0, inexact_o}, {31'b0, mx.inx});
      end else if (done_o) begin
        chk("spurious_done", {31'b0, done_o}, 32'd0);
      end
    end
  end
  initial begin
    exp_t x;
    logic [31:0] r;
    int k;
    tbl[0]  = '{32'h40490FDB, 32'h00000003, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    #3 rst_n_i = 1'b0;
    #1;
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_flags", {29'b0, overflow_o, exception_o, inexact_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    x = '{id: 0, due: 0, res: 32'h3, ovf: 1'b0, exc: 1'b0, inx: 1'b1};
    issue(1'b1, 32'h40490FDB, x);
    issue(1'b0, 32'h0, x);
    drain();
    repeat (3) issue(1'b0, 32'h0, x);
    foreach (tbl[i]) begin
      x = '{id: 100 + i, due: 0, res: tbl[i].res, ovf: tbl[i].ovf, exc: tbl[i].exc, inx: tbl[i].inx};
      issue(1'b1, tbl[i].op, x);
    end
    issue(1'b0, 32'h0, x);
    drain();
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      r = $urandom;
      r[30:23] = k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'(100 + $urandom_range(0, 60));
      if ($urandom_range(0, 4) == 0) r[22:0] = '0;
      issue($urandom_range(0, 3) != 0, r, model(r, 1000 + i));
    end
    issue(1'b0, 32'h0, x);
    drain();
    repeat (6) issue(1'b0, 32'h3F800000, x);
    issue(1'b1, 32'h3F800000, model(32'h3F800000, 2000));
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_res", res_o, 32'd0);
    chk("midrst_flags", {29'b0, overflow_o, exception_o, inexact_o}, 32'd0);
    q.delete();
    #4 rst_n_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done[%0d]", i), {31'b0, done_o}, 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iob_fp_float2int.md
# iob_fp_float2int

Pipelined IEEE-754-style float-to-signed-integer converter for the `iob_fp_*` arithmetic family. It accepts one packed float per cycle under a `start_i`/`done_o` strobe and returns a two's-complement integer, truncated toward zero (C cast semantics). It saturates on overflow and flags invalid and inexact inputs. It sits beside `iob_fp_add` in the FP datapath, on the path that takes FP results back into the integer domain.

## Interface
- `DATA_W`, 32: packed float width (sign + exponent + fraction).
- `EXP_W`, 8: exponent width.
- `INT_W`, 32: integer result width.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  input-valid strobe; `op_i` is sampled on the same edge.
- `op_i`  in  DATA_W  packed float operand.
- `done_o`  out  1  result-valid strobe, one cycle per accepted `start_i`.
- `res_o`  out  INT_W  two's-complement result.
- `overflow_o`  out  1  magnitude out of range, or ±inf; result saturated.
- `exception_o`  out  1  operand was NaN or ±inf.
- `inexact_o`  out  1  nonzero fraction bits were discarded.

## Operation
- MAN_W = DATA_W−EXP_W (hidden bit included). BIAS = 2^(EXP_W−1)−1. e = exp − BIAS, computed signed with EXP_W+1 bits.
- Classify the operand:
  - Zero: exp==0, frac==0. Result 0, all flags 0.
  - Subnormal: exp==0, frac≠0. Flushed; result 0, `inexact_o`=1.
  - e<0: result 0, `inexact_o`=1.
  - NaN: exp all-ones, frac≠0. Result 2^(INT_W−1)−1, `exception_o`=1, `overflow_o`=0.
  - ±inf: result saturated by sign, `exception_o`=1, `overflow_o`=1.
- Normal path: magnitude = {1,frac}.
  - If e ≥ MAN_W−1: shift left by e−(MAN_W−1).
  - Otherwise: shift right by (MAN_W−1)−e. `inexact_o` is the OR of all bits shifted out.
- Range check, applied when e ≥ INT_W−1:
  - Overflow: saturate to 2^(INT_W−1)−1 (positive) or −2^(INT_W−1) (negative), `overflow_o`=1, `inexact_o`=0.
  - Exception: sign=1, e==INT_W−1, frac==0 is exactly −2^(INT_W−1). It is not an overflow.
- Sign applied last: the result is the two's-complement negation of the magnitude when sign=1. −0.0 gives 0.
- Flags are valid only while `done_o`=1.

## Timing
- Fixed three-stage pipeline, no stalls, no backpressure. Full throughput: one operand per cycle.
- Latency: `start_i` high at edge k → `done_o` and the result are high/valid in the cycle after edge k+3.
- Ordering: results leave in issue order. Back-to-back starts give back-to-back dones.
- Stages:
  - S1: register sign, exponent, mantissa, class bits and e.
  - S2: barrel shift, inexact reduction, range check.
  - S3: negate/saturate mux, registered outputs.
- Datapath registers load every cycle regardless of `start_i`. Only the valid chain is gated by `start_i`.
- Reset values: `done_o`=0, `res_o`=0, `overflow_o`=0, `exception_o`=0, `inexact_o`=0, all pipeline registers 0.
- Reset mid-operation: `rst_n_i` low clears everything asynchronously, outputs included. In-flight operands are dropped. No `done_o` follows reset release unless `start_i` is reasserted.
- The first `start_i` is accepted on the first rising edge with `rst_n_i` high.

## Structure
- Shared FP package/header, common to the `iob_fp_*` blocks:
  - MAN_W, BIAS.
  - Canonical NAN and INF(sign) macros.
  - Saturation constants INT_MAX/INT_MIN as functions of INT_W.
- Sub-module: reuse `iob_fp_special` on `op_i` for nan/infinite/zero/sub_normal classification. Do not re-derive it locally.
- Shifter, negation and saturation stay inline. Target is about 200 lines.

## Test plan
All scenarios use DATA_W=32, EXP_W=8, INT_W=32.
- 0x40490FDB (π) → `res_o`=0x00000003, `inexact_o`=1, `done_o` in the cycle after the third edge following the start edge. 0xC2F6E979 (−123.456) → 0xFFFFFF85, `inexact_o`=1.
- 0x4F000000 (2^31) → 0x7FFFFFFF, `overflow_o`=1. 0xCF000000 (−2^31) → 0x80000000, `overflow_o`=0, `inexact_o`=0.
- 0x7FC00000 (NaN) → 0x7FFFFFFF, `exception_o`=1, `overflow_o`=0. 0xFF800000 (−inf) → 0x80000000, `exception_o`=1, `overflow_o`=1.
- Four starts on consecutive cycles:
  - 0x3F800000 → 1, `inexact_o`=0.
  - 0x3F000000 → 0, `inexact_o`=1.
  - 0x00000001 → 0, `inexact_o`=1.
  - 0x80000000 → 0, all flags 0.
  - `done_o` is high for exactly four consecutive cycles, results in order.
- 0x4B000001 (8388609.0) → 0x00800001, `inexact_o`=0. 0x4EFFFFFF → 0x7FFFFF80, `overflow_o`=0 (left-shift path, largest in-range value).
- Start 0x3F800000, pull `rst_n_i` low for half a cycle one cycle later → all outputs 0 immediately. No `done_o` for 10 cycles after release.
